// File: rtl/picomips_alu.sv
// picomips_alu
//   Two-operand arithmetic unit for the picoMIPS datapath. It registers its result,
//   so the result is valid one clock after the operands are presented.
//   Functions: PASSB, SUB, ADD, and a fractional MUL, where a is a signed
//   Q1.(n-1) fraction and b is a signed integer.
//
// Ports
//   clk      in   1   system clock, rising edge
//   reset    in   1   asynchronous reset, active high
//   a        in   n   operand A (Q1.(n-1) fraction for MUL, integer otherwise)
//   b        in   n   operand B (two's-complement integer)
//   ALUFunc  in   2   00 PASSB, 01 SUB, 10 ADD, 11 MUL
//   result   out  n   registered result
//   zero     out  1   registered flag, set when the registered result is all-zero
module picomips_alu #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic [1:0]   ALUFunc,
  output logic [n-1:0] result,
  output logic         zero
);

  localparam logic [1:0] FN_PASSB = 2'b00;
  localparam logic [1:0] FN_SUB   = 2'b01;
  localparam logic [1:0] FN_ADD   = 2'b10;
  localparam logic [1:0] FN_MUL   = 2'b11;

  logic signed [2*n-1:0] a_ext;
  logic signed [2*n-1:0] b_ext;
  logic        [n-1:0]   mul_res;
  logic        [n-1:0]   result_d;
  logic        [n-1:0]   result_q;
  logic                  zero_q;

  // The operands are sign-extended to 2n bits so that the 2n-bit product is exact.
  // An arithmetic shift by n-1 drops the fraction bits, which rounds toward
  // -infinity. Keeping only the low n bits lets an out-of-range product wrap.
  assign a_ext   = {{n{a[n-1]}}, a};
  assign b_ext   = {{n{b[n-1]}}, b};
  assign mul_res = n'((a_ext * b_ext) >>> (n - 1));

  always_comb begin
    result_d = b;
    case (ALUFunc)
      FN_PASSB: result_d = b;
      FN_SUB:   result_d = a - b;
      FN_ADD:   result_d = a + b;
      FN_MUL:   result_d = mul_res;
      default:  result_d = b;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      result_q <= result_d;
      zero_q   <= (result_d == '0);
    end
  end

  assign result = result_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_picomips_alu.sv
module tb_picomips_alu;

  logic       clk;
  logic       reset;
  logic [7:0] a;
  logic [7:0] b;
  logic [1:0] ALUFunc;
  logic [7:0] result;
  logic       zero;

  int n_checks = 0;
  int n_fails  = 0;

  picomips_alu #(.n(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .a       (a),
    .b       (b),
    .ALUFunc (ALUFunc),
    .result  (result),
    .zero    (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: signed integer arithmetic on the operand values.
  function automatic logic [7:0] ref_alu(input logic [7:0] x, input logic [7:0] y,
                                         input logic [1:0] fn);
    int sx;
    int sy;
    int r;
    sx = int'($signed(x));
    sy = int'($signed(y));
    case (fn)
      2'd0:    r = sy;
      2'd1:    r = sx - sy;
      2'd2:    r = sx + sy;
      default: r = (sx * sy) >>> 7;
    endcase
    return r[7:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive on the falling edge, then check just after the next rising edge.
  task automatic do_op(input string tag, input logic [7:0] x, input logic [7:0] y,
                       input logic [1:0] fn);
    logic [7:0] e;
    @(negedge clk);
    a = x; b = y; ALUFunc = fn;
    e = ref_alu(x, y, fn);
    @(posedge clk);
    #1;
    check({tag, "_result"}, 32'(result), 32'(e));
    check({tag, "_zero"}, 32'(zero), 32'(e == 8'h00));
  endtask

  initial begin
    logic [7:0] e;
    logic [7:0] rx, ry;
    logic [1:0] rf;

    // Reset applied before any clock edge.
    reset = 1'b1; a = 8'h37; b = 8'h91; ALUFunc = 2'b11;
    #2;
    check("rst_async_result", 32'(result), 32'h0);
    check("rst_async_zero", 32'(zero), 32'h1);
    @(posedge clk); #1;
    check("rst_hold_result", 32'(result), 32'h0);

    // Release between edges: the outputs hold until the next edge.
    @(negedge clk);
    reset = 1'b0; a = 8'd3; b = 8'd20; ALUFunc = 2'b10;
    #1;
    check("rel_hold_result", 32'(result), 32'h0);
    check("rel_hold_zero", 32'(zero), 32'h1);
    @(posedge clk); #1;
    check("add_3_20", 32'(result), 32'd23);
    check("add_3_20_zero", 32'(zero), 32'h0);

    // Directed cases.
    do_op("add_wrap", 8'd200, 8'd100, 2'b10);
    check("add_wrap_const", 32'(result), 32'd44);
    do_op("mul_075x5", 8'b0110_0000, 8'd5, 2'b11);
    check("mul_075x5_const", 32'(result), 32'd3);
    do_op("mul_m05x10", 8'hC0, 8'd10, 2'b11);
    check("mul_m05x10_const", 32'(result), 32'hFB);
    do_op("sub_eq", 8'd5, 8'd5, 2'b01);
    check("sub_eq_zero_const", 32'(zero), 32'h1);
    do_op("sub_neg", 8'd3, 8'd4, 2'b01);
    check("sub_neg_const", 32'(result), 32'hFF);
    do_op("passb", 8'hAA, 8'h5C, 2'b00);
    check("passb_const", 32'(result), 32'h5C);
    do_op("mul_minmin", 8'h80, 8'h80, 2'b11);
    do_op("mul_neg_floor", 8'hFF, 8'd1, 2'b11);
    do_op("mul_wrap", 8'h7F, 8'h7F, 2'b11);

    // Changing the inputs between edges must not disturb the outputs.
    #2;
    a = 8'h12; b = 8'h34; ALUFunc = 2'b10;
    #2;
    check("between_edges", 32'(result), 32'(ref_alu(8'h7F, 8'h7F, 2'b11)));

    // Back-to-back operations with ALUFunc changing every cycle.
    for (int i = 0; i < 8; i++)
      do_op("pipe", 8'($urandom), 8'($urandom), 2'(i));

    // Reset between edges while a MUL is pending.
    do_op("pre_rst", 8'h40, 8'd6, 2'b10);
    @(negedge clk);
    a = 8'h60; b = 8'd9; ALUFunc = 2'b11;
    #2;
    reset = 1'b1;
    #1;
    check("midrst_result", 32'(result), 32'h0);
    check("midrst_zero", 32'(zero), 32'h1);
    @(posedge clk); #1;
    check("midrst_edge_result", 32'(result), 32'h0);
    @(negedge clk);
    reset = 1'b0; a = 8'hA0; b = 8'd7; ALUFunc = 2'b11;
    e = ref_alu(8'hA0, 8'd7, 2'b11);
    #1;
    check("midrst_rel_hold", 32'(result), 32'h0);
    @(posedge clk); #1;
    check("midrst_load_result", 32'(result), 32'(e));
    check("midrst_load_zero", 32'(zero), 32'(e == 8'h00));

    // Randomized operations against the model.
    for (int i = 0; i < 300; i++) begin
      rx = 8'($urandom);
      ry = 8'($urandom);
      rf = 2'($urandom_range(0, 3));
      if (i % 17 == 0) ry = (rf == 2'b00) ? 8'h00 : rx;
      do_op("rand", rx, ry, rf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
